// File: rtl/rxd.sv
// UART receiver: synchronises uart_rx, finds the start edge, samples each bit
// mid-bit from an internal baud counter and reports word, parity and framing status.
module rxd #(
  parameter int    CLK_FREQUENCE = 50_000_000,
  parameter int    BPS           = 9600,
  parameter string PARITY_BIT    = "NONE",
  parameter int    FRAME_WD      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                uart_rx,
  output logic [FRAME_WD-1:0] rx_data,
  output logic                rx_done,
  output logic                parity_err,
  output logic                frame_err,
  output logic                rx_busy
);

  localparam int N     = CLK_FREQUENCE / BPS;
  localparam int HALF  = N / 2;
  localparam int CNT_W = $clog2(N);
  localparam int BIT_W = $clog2(FRAME_WD);

  localparam bit P_NONE = (PARITY_BIT == "NONE");
  localparam bit P_EVEN = (PARITY_BIT == "EVEN");
  localparam bit P_ODD  = (PARITY_BIT == "ODD");

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_WD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  logic                r_s1;
  logic                r_s2;
  logic                r_s3;
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [FRAME_WD-1:0] r_shift;
  logic                r_p;
  logic                r_stop;

  logic w_start_det;
  logic w_cnt_last;

  assign w_start_det = r_s3 & ~r_s2;
  assign w_cnt_last  = (r_cnt == CNT_LAST);

  // Two-flop synchroniser plus one delay flop for falling-edge detection; idle line is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= uart_rx;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_p        <= 1'b0;
      r_stop     <= 1'b0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_start_det) begin
            r_state <= S_START;
            rx_busy <= 1'b1;
          end
        end
        // Half-bit check of the start bit filters glitches shorter than HALF clocks.
        S_START: begin
          if (r_cnt == CNT_MID) begin
            r_cnt <= '0;
            if (!r_s2) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_cnt_last) begin
            r_cnt              <= '0;
            r_shift[r_bit_cnt] <= r_s2;
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= S_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_p     <= r_s2;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // Leaving mid-stop-bit lets IDLE catch a back-to-back start edge.
        S_STOP: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_stop  <= r_s2;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          rx_done <= 1'b1;
          rx_data <= r_shift;
          if (P_NONE) begin
            frame_err <= ~r_stop | ~r_p;
          end else begin
            frame_err <= ~r_stop;
          end
          if (P_EVEN) begin
            parity_err <= (r_p != (^r_shift));
          end else if (P_ODD) begin
            parity_err <= (r_p != (~^r_shift));
          end else begin
            parity_err <= 1'b0;
          end
          r_cnt   <= '0;
          r_state <= S_IDLE;
          rx_busy <= 1'b0;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rxd.sv
// Bench for rxd: twelve receivers cover FRAME_WD 5..8 in every parity mode,
// each fed by a behavioural serial transmitter and checked against a frame model.
module tb_rxd;

  localparam int N    = 16;
  localparam int HALF = 8;
  localparam int NI   = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0] rx_line = '1;

  logic [7:0]    d_a [NI];
  logic [NI-1:0] done_a;
  logic [NI-1:0] perr_a;
  logic [NI-1:0] ferr_a;
  logic [NI-1:0] busy_a;

  int            done_cnt [NI];
  int            exp_cnt  [NI];
  longint        done_t   [NI];
  logic [NI-1:0] prev_busy = '0;
  logic [NI-1:0] busy_before = '0;
  logic [NI-1:0] busy_at = '0;
  longint        t_start = 0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instance k: FRAME_WD = 5 + k/3, parity mode k%3 (0 NONE, 1 EVEN, 2 ODD).
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int    FW = 5 + g / 3;
    localparam string PM = (g % 3 == 0) ? "NONE" : ((g % 3 == 1) ? "EVEN" : "ODD");
    logic [FW-1:0] w_d;
    rxd #(
      .CLK_FREQUENCE(16),
      .BPS          (1),
      .PARITY_BIT   (PM),
      .FRAME_WD     (FW)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_rx   (rx_line[g]),
      .rx_data   (w_d),
      .rx_done   (done_a[g]),
      .parity_err(perr_a[g]),
      .frame_err (ferr_a[g]),
      .rx_busy   (busy_a[g])
    );
    assign d_a[g] = 8'(w_d);
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (done_a[g]) begin
        done_cnt[g]    <= done_cnt[g] + 1;
        done_t[g]      <= $time;
        busy_before[g] <= prev_busy[g];
        busy_at[g]     <= busy_a[g];
      end
    end
    prev_busy <= busy_a;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int fw_of(input int k);
    return 5 + k / 3;
  endfunction

  function automatic logic [7:0] mask_of(input int k, input logic [7:0] d);
    logic [7:0] m;
    m = 8'((1 << fw_of(k)) - 1);
    return d & m;
  endfunction

  function automatic logic ones_odd(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  // Parity bit a correct transmitter would send for instance k.
  function automatic logic good_p(input int k, input logic [7:0] d);
    case (k % 3)
      1:       return ones_odd(mask_of(k, d));
      2:       return ~ones_odd(mask_of(k, d));
      default: return 1'b1;
    endcase
  endfunction

  task automatic put(input int k, input logic b);
    rx_line[k] = b;
    repeat (N) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [7:0] d, input logic p, input logic stp);
    @(negedge clk);
    t_start = $time;
    put(k, 1'b0);
    for (int i = 0; i < fw_of(k); i++) put(k, d[i]);
    put(k, p);
    put(k, stp);
  endtask

  task automatic check_frame(input int k, input logic [7:0] d, input logic p, input logic stp);
    logic [7:0] dm;
    logic       odd;
    logic       ep;
    logic       ef;
    int         fw;
    fw  = fw_of(k);
    dm  = mask_of(k, d);
    odd = ones_odd(dm);
    case (k % 3)
      1:       begin ep = (p != odd); ef = ~stp; end
      2:       begin ep = (p == odd); ef = ~stp; end
      default: begin ep = 1'b0;       ef = ~stp | ~p; end
    endcase
    exp_cnt[k]++;
    chk($sformatf("k%0d done_count", k), done_cnt[k], exp_cnt[k]);
    chk($sformatf("k%0d rx_data", k), d_a[k], dm);
    chk($sformatf("k%0d parity_err", k), perr_a[k], ep);
    chk($sformatf("k%0d frame_err", k), ferr_a[k], ef);
    // 3 cycles of synchroniser/edge detect, HALF to the start sample, (fw+2) bit periods, 1 DONE cycle.
    chk($sformatf("k%0d latency", k), 32'(done_t[k] - t_start), 32'((4 + HALF + (fw + 2) * N) * 10));
    chk($sformatf("k%0d busy_idle", k), busy_a[k], 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    int         k;

    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("k%0d rst_data", g), d_a[g], 0);
      chk($sformatf("k%0d rst_done", g), done_a[g], 0);
      chk($sformatf("k%0d rst_perr", g), perr_a[g], 0);
      chk($sformatf("k%0d rst_ferr", g), ferr_a[g], 0);
      chk($sformatf("k%0d rst_busy", g), busy_a[g], 0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // NONE, 8 bits
    send_frame(9, 8'hA5, 1'b1, 1'b1);
    check_frame(9, 8'hA5, 1'b1, 1'b1);
    chk("busy_before_done", busy_before[9], 1'b1);
    chk("busy_at_done", busy_at[9], 1'b0);

    // EVEN, 8 bits
    send_frame(10, 8'h07, 1'b1, 1'b1);
    check_frame(10, 8'h07, 1'b1, 1'b1);
    send_frame(10, 8'h07, 1'b0, 1'b1);
    check_frame(10, 8'h07, 1'b0, 1'b1);

    // ODD, 5 bits
    send_frame(2, 8'h00, 1'b1, 1'b1);
    check_frame(2, 8'h00, 1'b1, 1'b1);
    send_frame(2, 8'h1F, 1'b1, 1'b1);
    check_frame(2, 8'h1F, 1'b1, 1'b1);

    // Framing error, then line held low: no new frame without an edge
    send_frame(9, 8'h3C, 1'b1, 1'b0);
    check_frame(9, 8'h3C, 1'b1, 1'b0);
    repeat (3 * N) @(negedge clk);
    chk("stuck_low_done_count", done_cnt[9], exp_cnt[9]);
    chk("stuck_low_busy", busy_a[9], 1'b0);
    rx_line[9] = 1'b1;
    repeat (N) @(negedge clk);
    send_frame(9, 8'h55, 1'b1, 1'b1);
    check_frame(9, 8'h55, 1'b1, 1'b1);

    // Start glitch shorter than HALF
    @(negedge clk);
    rx_line[9] = 1'b0;
    repeat (3) @(negedge clk);
    rx_line[9] = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_high", busy_a[9], 1'b1);
    repeat (20) @(negedge clk);
    chk("glitch_busy_low", busy_a[9], 1'b0);
    chk("glitch_done_count", done_cnt[9], exp_cnt[9]);
    send_frame(9, 8'h81, 1'b1, 1'b1);
    check_frame(9, 8'h81, 1'b1, 1'b1);

    // Reset during data bit 4
    fork
      send_frame(9, 8'hFF, 1'b1, 1'b1);
      begin
        repeat (N * 5 + 8) @(negedge clk);
        chk("pre_rst_busy", busy_a[9], 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_data", d_a[9], 0);
        chk("mid_rst_done", done_a[9], 0);
        chk("mid_rst_perr", perr_a[9], 0);
        chk("mid_rst_ferr", ferr_a[9], 0);
        chk("mid_rst_busy", busy_a[9], 0);
        rst_n = 1'b1;
      end
    join
    repeat (N) @(negedge clk);
    chk("post_rst_done_count", done_cnt[9], exp_cnt[9]);
    chk("post_rst_busy", busy_a[9], 1'b0);
    send_frame(9, 8'h5A, 1'b1, 1'b1);
    check_frame(9, 8'h5A, 1'b1, 1'b1);

    // Back-to-back random frames from a correct transmitter across all configurations
    for (int i = 0; i < 50; i++) begin
      k = int'($urandom_range(0, NI - 1));
      d = 8'($urandom);
      p = good_p(k, d);
      send_frame(k, d, p, 1'b1);
      check_frame(k, d, p, 1'b1);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
